// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types, depth helpers and default thresholds for sync_fifo_ext
package sync_fifo_pkg;

    localparam int DEFAULT_AEMPTY_THRESH = 2;
    localparam int DEFAULT_AFULL_MARGIN  = 2;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_status_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int fifo_addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - register array with one write port and one asynchronous read port
module sync_fifo_mem #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ext.sv
// rtl/sync_fifo_ext.sv - single-clock FIFO with fill level, thresholds and optional FWFT read
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - DEFAULT_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    input  logic                  err_clr_i,
    output logic                  overflow_o,
    output logic                  underflow_o
`endif
);

    localparam logic [ADDR_WIDTH:0] AFULL_T  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_T = AEMPTY_THRESH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    fifo_status_t          status;

    // Extra wrap bit separates full (same address, other lap) from empty.
    always_comb begin
        status.empty  = (wr_ptr == rd_ptr);
        status.full   = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                        (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        status.afull  = (count_o >= AFULL_T);
        status.aempty = (count_o <= AEMPTY_T);
    end

    assign full_o         = status.full;
    assign empty_o        = status.empty;
    assign almost_full_o  = status.afull;
    assign almost_empty_o = status.aempty;

    assign wr_ok = wr_en_i && !status.full;
    assign rd_ok = rd_en_i && !status.empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    sync_fifo_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk    (clk_i),
        .wr_en  (wr_ok),
        .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data(wr_data_i),
        .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data(mem_rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        assign rd_data_o = mem_rd_data;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rd_q <= '0;
            end else if (rd_ok) begin
                rd_q <= mem_rd_data;
            end
        end
        assign rd_data_o = rd_q;
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_en_i && status.full) overflow_o <= 1'b1;
            else if (err_clr_i)         overflow_o <= 1'b0;
            if (rd_en_i && status.empty) underflow_o <= 1'b1;
            else if (err_clr_i)          underflow_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb/tb_sync_fifo_ext.sv - scoreboard bench for sync_fifo_ext (standard and FWFT instances)
module tb_sync_fifo_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        full, empty, afull, aempty;
    logic [4:0]  count;

    logic        f_wr_en, f_rd_en;
    logic [15:0] f_wr_data;
    logic [15:0] f_rd_data;
    logic        f_full, f_empty, f_afull, f_aempty;
    logic [4:0]  f_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic        err_clr, ovf, unf;
    logic        f_err_clr, f_ovf, f_unf;
`endif

    int          tests = 0;
    int          fails = 0;
    int          mcount = 0;
    logic [15:0] exp_q[$];
    logic        fire = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_ext dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
        .rd_data_o(rd_data), .full_o(full), .empty_o(empty), .almost_full_o(afull),
        .almost_empty_o(aempty), .count_o(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .err_clr_i(err_clr), .overflow_o(ovf), .underflow_o(unf)
`endif
    );

    sync_fifo_ext #(.FWFT(1)) dut_f (
        .clk_i(clk), .rst_i(rst), .wr_en_i(f_wr_en), .wr_data_i(f_wr_data), .rd_en_i(f_rd_en),
        .rd_data_o(f_rd_data), .full_o(f_full), .empty_o(f_empty), .almost_full_o(f_afull),
        .almost_empty_o(f_aempty), .count_o(f_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .err_clr_i(f_err_clr), .overflow_o(f_ovf), .underflow_o(f_unf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a read handshake at the edge means a word is presented after it.
    always @(posedge clk) fire <= rd_en && !empty;

    always @(negedge clk) begin
        if (fire) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: got %0h expected none", rd_data);
            end else begin
                chk("rd_data", {16'h0, rd_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input logic w, input logic [15:0] d, input logic r);
        bit wok, rok;
        wok = w && (mcount < 16);
        rok = r && (mcount > 0);
        wr_en = w; wr_data = d; rd_en = r;
        if (wok) exp_q.push_back(d);
        mcount = mcount + int'(wok) - int'(rok);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        chk("count", {27'h0, count}, mcount);
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; rd_en = 0; wr_data = 0;
        f_wr_en = 0; f_rd_en = 0; f_wr_data = 0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 0; f_err_clr = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_aempty", aempty, 1);
        chk("rst_afull", afull, 0);
        chk("rst_rd_data", rd_data, 0);

        for (int i = 0; i < 5; i++) step(1, 16'(50 + i), 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_empty", empty, 1);
        exp_q.delete();
        mcount = 0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= 16; i++) step(1, 16'(i), 0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        step(1, 16'd99, 0);
        chk("drop_full", full, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 1);
        chk("drain_empty", empty, 1);

        for (int i = 0; i < 10; i++) step(1, 16'(20 + i), 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 16'(100 + i), 0);
        chk("wrap_full", full, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 1);
        chk("wrap_empty", empty, 1);

        for (int i = 0; i < 8; i++) step(1, 16'(200 + i), 0);
        for (int i = 0; i < 20; i++) step(1, 16'(300 + i), 1);
        for (int i = 0; i < 8; i++) step(1, 16'(400 + i), 0);
        chk("conc_full", full, 1);
        step(1, 16'd999, 1);
        chk("conc_full_rd_count", count, 15);
        chk("conc_full_rd_full", full, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 1);

        for (int i = 1; i <= 16; i++) begin
            step(1, 16'(500 + i), 0);
            chk("afull_up", afull, (mcount >= 14));
            chk("aempty_up", aempty, (mcount <= 2));
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1);
            chk("afull_dn", afull, (mcount >= 14));
            chk("aempty_dn", aempty, (mcount <= 2));
        end

        f_wr_en = 1; f_wr_data = 16'h00A5;
        @(negedge clk);
        f_wr_en = 0;
        chk("fwft_first", f_rd_data, 16'h00A5);
        chk("fwft_not_empty", f_empty, 0);
        f_wr_en = 1; f_wr_data = 16'h005A;
        @(negedge clk);
        f_wr_en = 0;
        chk("fwft_head_held", f_rd_data, 16'h00A5);
        f_rd_en = 1;
        @(negedge clk);
        f_rd_en = 0;
        chk("fwft_next", f_rd_data, 16'h005A);
        chk("fwft_count", f_count, 1);
        f_rd_en = 1;
        @(negedge clk);
        f_rd_en = 0;
        chk("fwft_empty", f_empty, 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        f_rd_en = 1;
        @(negedge clk);
        f_rd_en = 0;
        chk("underflow_set", f_unf, 1);
        chk("underflow_count", f_count, 0);
        @(negedge clk);
        chk("underflow_sticky", f_unf, 1);
        f_err_clr = 1;
        @(negedge clk);
        f_err_clr = 0;
        chk("underflow_clr", f_unf, 0);
`endif

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
